td4_reg_writeback: RTL and testbench

//   Write-back end of the datapath: the ALU result is demultiplexed into one of four

---
 rtl/td4_reg_writeback.sv | 67 ++++++
 tb/tb_td4_reg_writeback.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/td4_reg_writeback.sv
// rtl/td4_reg_writeback.sv - TD4 write-back: ALU result demux into A/B/OUT/PC plus carry flag
// Optional macro PC_HOLD_EN enables the hold input to freeze all architectural state.
module td4_reg_writeback #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             we,
  input  logic [1:0]       dest,
  input  logic [WIDTH-1:0] wdata,
  input  logic             carry_we,
  input  logic             carry_in,
  input  logic             hold,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] reg_out,
  output logic [WIDTH-1:0] pc,
  output logic             carry_flag,
  output logic             pc_wrap
);

  logic freeze;
  logic pc_load;

`ifdef PC_HOLD_EN
  assign freeze = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign freeze      = 1'b0;
`endif

  assign pc_load = we && (dest == 2'b11);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      reg_a      <= '0;
      reg_b      <= '0;
      reg_out    <= '0;
      pc         <= '0;
      carry_flag <= 1'b0;
      pc_wrap    <= 1'b0;
    end else if (freeze) begin
      pc_wrap <= 1'b0;
    end else begin
      if (we) begin
        case (dest)
          2'b00:   reg_a   <= wdata;
          2'b01:   reg_b   <= wdata;
          2'b10:   reg_out <= wdata;
          default: ;
        endcase
      end
      // A jump replaces the increment outright, so it can never report a wrap.
      if (pc_load) begin
        pc      <= wdata;
        pc_wrap <= 1'b0;
      end else begin
        pc      <= pc + 1'b1;
        pc_wrap <= (pc == '1);
      end
      if (carry_we)
        carry_flag <= carry_in;
    end
  end

endmodule

// File: tb/tb_td4_reg_writeback.sv
// tb/tb_td4_reg_writeback.sv - self-checking bench for td4_reg_writeback (honours PC_HOLD_EN)
module tb_td4_reg_writeback;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         n_reset, we, carry_we, carry_in, hold;
  logic [1:0]   dest;
  logic [W-1:0] wdata;
  logic [W-1:0] reg_a, reg_b, reg_out, pc;
  logic         carry_flag, pc_wrap;

  int tests = 0;
  int fails = 0;

  // Reference state: index 0..3 mirrors the dest code (A, B, OUT, PC).
  int m_r[4];
  int m_c;
  int m_w;

  always #5 clk = ~clk;

  td4_reg_writeback #(.WIDTH(W)) dut (
    .clk(clk), .n_reset(n_reset), .we(we), .dest(dest), .wdata(wdata),
    .carry_we(carry_we), .carry_in(carry_in), .hold(hold),
    .reg_a(reg_a), .reg_b(reg_b), .reg_out(reg_out), .pc(pc),
    .carry_flag(carry_flag), .pc_wrap(pc_wrap)
  );

  typedef struct {
    logic       rst_n, we;
    logic [1:0] dest;
    logic [3:0] wd;
    logic       cwe, cin, hold;
    logic [3:0] ea, eb, eo, ep;
    logic       ec, ew;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic w, input logic [1:0] d,
                              input logic [3:0] wd, input logic cwe, input logic cin,
                              input logic [3:0] ea, input logic [3:0] eb,
                              input logic [3:0] eo, input logic [3:0] ep,
                              input logic ec, input logic ew);
    vec_t v;
    v.rst_n = r; v.we = w; v.dest = d; v.wd = wd; v.cwe = cwe; v.cin = cin;
    v.hold = 1'b0; v.ea = ea; v.eb = eb; v.eo = eo; v.ep = ep; v.ec = ec; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ea, input int eb, input int eo,
                         input int ep, input int ec, input int ew);
    chk({tag, ".reg_a"},      32'(reg_a),      32'(ea));
    chk({tag, ".reg_b"},      32'(reg_b),      32'(eb));
    chk({tag, ".reg_out"},    32'(reg_out),    32'(eo));
    chk({tag, ".pc"},         32'(pc),         32'(ep));
    chk({tag, ".carry_flag"}, 32'(carry_flag), 32'(ec));
    chk({tag, ".pc_wrap"},    32'(pc_wrap),    32'(ew));
  endtask

  // Applies one instruction's worth of inputs, advances the model, clocks the DUT.
  task automatic step(input logic r, input logic w, input logic [1:0] d, input logic [3:0] wd,
                      input logic cwe, input logic cin, input logic h);
    bit hold_eff;
    n_reset = r; we = w; dest = d; wdata = wd; carry_we = cwe; carry_in = cin; hold = h;
`ifdef PC_HOLD_EN
    hold_eff = h;
`else
    hold_eff = 1'b0;
`endif
    if (!r) begin
      m_r = '{0, 0, 0, 0}; m_c = 0; m_w = 0;
    end else if (hold_eff) begin
      m_w = 0;
    end else begin
      bit jump;
      jump = w && (d == 2'd3);
      m_w  = (!jump && m_r[3] == MOD - 1) ? 1 : 0;
      if (w) m_r[d] = int'(wd);
      if (!jump) m_r[3] = (m_r[3] + 1) % MOD;
      if (cwe) m_c = int'(cin);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b0; we = 1'b0; dest = 2'd0; wdata = '0;
    carry_we = 1'b0; carry_in = 1'b0; hold = 1'b0;
    m_r = '{0, 0, 0, 0}; m_c = 0; m_w = 0;

    //           rst we dest wd    cwe cin  A     B     OUT   PC    c  wrap
    tbl.push_back(mk(0, 1, 2'd0, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 1, 2'd0, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 1, 2'd0, 4'h3, 0, 0, 4'h3, 4'h0, 4'h0, 4'h1, 0, 0));
    tbl.push_back(mk(1, 1, 2'd1, 4'h5, 0, 0, 4'h3, 4'h5, 4'h0, 4'h2, 0, 0));
    tbl.push_back(mk(1, 1, 2'd2, 4'h9, 0, 0, 4'h3, 4'h5, 4'h9, 4'h3, 0, 0));
    tbl.push_back(mk(1, 0, 2'd0, 4'hC, 0, 0, 4'h3, 4'h5, 4'h9, 4'h4, 0, 0));
    tbl.push_back(mk(1, 1, 2'd3, 4'hA, 0, 0, 4'h3, 4'h5, 4'h9, 4'hA, 0, 0));
    tbl.push_back(mk(1, 0, 2'd3, 4'h1, 0, 0, 4'h3, 4'h5, 4'h9, 4'hB, 0, 0));
    tbl.push_back(mk(1, 1, 2'd3, 4'hE, 0, 0, 4'h3, 4'h5, 4'h9, 4'hE, 0, 0));
    tbl.push_back(mk(1, 0, 2'd0, 4'h0, 0, 0, 4'h3, 4'h5, 4'h9, 4'hF, 0, 0));
    tbl.push_back(mk(1, 0, 2'd1, 4'h0, 0, 0, 4'h3, 4'h5, 4'h9, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 2'd2, 4'h0, 0, 0, 4'h3, 4'h5, 4'h9, 4'h1, 0, 0));
    tbl.push_back(mk(1, 1, 2'd1, 4'h7, 1, 1, 4'h3, 4'h7, 4'h9, 4'h2, 1, 0));
    tbl.push_back(mk(1, 0, 2'd1, 4'h0, 0, 0, 4'h3, 4'h7, 4'h9, 4'h3, 1, 0));
    tbl.push_back(mk(1, 1, 2'd3, 4'hF, 0, 0, 4'h3, 4'h7, 4'h9, 4'hF, 1, 0));
    tbl.push_back(mk(1, 1, 2'd3, 4'h0, 0, 1, 4'h3, 4'h7, 4'h9, 4'h0, 1, 0));
    tbl.push_back(mk(1, 0, 2'd3, 4'h5, 1, 0, 4'h3, 4'h7, 4'h9, 4'h1, 0, 0));
    tbl.push_back(mk(1, 1, 2'd2, 4'h6, 1, 1, 4'h3, 4'h7, 4'h6, 4'h2, 1, 0));
    tbl.push_back(mk(0, 1, 2'd1, 4'h8, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].we, tbl[i].dest, tbl[i].wd, tbl[i].cwe, tbl[i].cin, tbl[i].hold);
      chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eo, tbl[i].ep,
              tbl[i].ec, tbl[i].ew);
    end

    // Hold corner: PC parked at F, then freeze with a pending write to A.
    step(1, 1, 2'd3, 4'hF, 0, 0, 0);
    chk_all("hold_setup", 0, 0, 0, 15, 0, 0);
    step(1, 1, 2'd0, 4'h6, 1, 1, 1);
`ifdef PC_HOLD_EN
    chk_all("hold_on", 0, 0, 0, 15, 0, 0);
    step(1, 0, 2'd0, 4'h0, 0, 0, 0);
    chk_all("hold_release", 0, 0, 0, 0, 0, 1);
    step(1, 1, 2'd0, 4'h6, 0, 0, 1);
    chk_all("hold_again", 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'd1, 4'h6, 0, 0, 1);
    chk_all("hold_reset", 0, 0, 0, 0, 0, 0);
`else
    chk_all("hold_ignored", 6, 0, 0, 0, 1, 1);
    step(0, 1, 2'd1, 4'h6, 0, 0, 1);
    chk_all("hold_reset", 0, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom), 2'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      chk_all($sformatf("rnd%0d", i), m_r[0], m_r[1], m_r[2], m_r[3], m_c, m_w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
